// File: rtl/usb_pkg.sv
// Shared encodings and constants for the USB transmitter: FSM states, SYNC
// pattern, bit-stuff limit, bit-period defaults and line-state helpers.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } txState_t;

  localparam logic [7:0] SYNC_PATTERN        = 8'h80;
  localparam logic [2:0] STUFF_LIMIT         = 3'd6;
  localparam int         FS_BIT_CLKS_DEFAULT = 5;
  localparam int         LS_BIT_CLKS_DEFAULT = 40;

  // Line states are written as {dm, dp}
  localparam logic [1:0] LINE_SE0  = 2'b00;
  localparam logic [1:0] LINE_J_FS = 2'b01;
  localparam logic [1:0] LINE_J_LS = 2'b10;

  function automatic logic [1:0] lineJ(input logic fs);
    return fs ? LINE_J_FS : LINE_J_LS;
  endfunction

  function automatic logic [1:0] lineK(input logic fs);
    return ~lineJ(fs);
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-period tick generator: one tick per FS_BIT_CLKS or LS_BIT_CLKS clocks,
// held at zero while clear is asserted so a packet starts on a full period.
module usb_bit_timer
  import usb_pkg::*;
#(
  parameter int FS_BIT_CLKS = FS_BIT_CLKS_DEFAULT,
  parameter int LS_BIT_CLKS = LS_BIT_CLKS_DEFAULT
) (
  input  logic clk60,
  input  logic reset,
  input  logic clear,
  input  logic fullspeed,
  output logic tick
);

  localparam int MAX_CLKS = (FS_BIT_CLKS > LS_BIT_CLKS) ? FS_BIT_CLKS : LS_BIT_CLKS;
  localparam int CW       = (MAX_CLKS > 2) ? $clog2(MAX_CLKS) : 1;

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_lastCount;

  assign w_lastCount = fullspeed ? CW'(FS_BIT_CLKS - 1) : CW'(LS_BIT_CLKS - 1);
  assign tick        = !clear && (r_count == w_lastCount);

  always_ff @(posedge clk60) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (r_count == w_lastCount) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/usb_tx.sv
// USB full/low-speed packet transmitter: SYNC, NRZI with bit stuffing, EOP,
// fed one byte at a time through a toggle-handshake holding register.
module usb_tx
  import usb_pkg::*;
#(
  parameter int FS_BIT_CLKS = FS_BIT_CLKS_DEFAULT,
  parameter int LS_BIT_CLKS = LS_BIT_CLKS_DEFAULT
) (
  input  logic       clk60,
  input  logic       reset,
  input  logic       fullspeed,
  input  logic [7:0] din,
  input  logic       last,
  input  logic       wrin,
  output logic       wrout,
  output logic       dp_out,
  output logic       dm_out,
  output logic       oe,
  output logic       transmitting,
  output logic       underrun
);

  txState_t   r_state;
  logic       r_fs;
  logic [7:0] r_hold;
  logic       r_holdLast;
  logic       r_holdValid;
  logic       r_wrout;
  logic [7:0] r_cur;
  logic       r_curLast;
  logic [3:0] r_bitCnt;
  logic [2:0] r_ones;
  logic [1:0] r_line;
  logic       r_oe;
  logic       r_trans;
  logic       r_underrun;

  logic w_tick;
  logic w_clear;
  logic w_capture;
  logic w_boundary;
  logic w_stuff;
  logic w_sendBit;

  assign w_clear    = (r_state == ST_IDLE);
  assign w_capture  = (wrin != r_wrout) && !r_holdValid;
  assign w_boundary = (r_bitCnt == 4'd8);
  assign w_stuff    = (r_ones == STUFF_LIMIT);
  assign w_sendBit  = w_boundary ? r_hold[0] : r_cur[0];

  usb_bit_timer #(
    .FS_BIT_CLKS(FS_BIT_CLKS),
    .LS_BIT_CLKS(LS_BIT_CLKS)
  ) u_bit_timer (
    .clk60    (clk60),
    .reset    (reset),
    .clear    (w_clear),
    .fullspeed(r_fs),
    .tick     (w_tick)
  );

  always_ff @(posedge clk60) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_fs        <= fullspeed;
      r_hold      <= '0;
      r_holdLast  <= 1'b0;
      r_holdValid <= 1'b0;
      r_wrout     <= 1'b0;
      r_cur       <= '0;
      r_curLast   <= 1'b0;
      r_bitCnt    <= '0;
      r_ones      <= '0;
      r_line      <= lineJ(fullspeed);
      r_oe        <= 1'b0;
      r_trans     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_fs    <= fullspeed;
          r_line  <= lineJ(fullspeed);
          r_oe    <= 1'b0;
          r_trans <= 1'b0;
          // The held byte stays put during SYNC; it is loaded at the SYNC boundary
          if (r_holdValid) begin
            r_state    <= ST_SYNC;
            r_line     <= SYNC_PATTERN[0] ? lineJ(fullspeed) : lineK(fullspeed);
            r_oe       <= 1'b1;
            r_trans    <= 1'b1;
            r_underrun <= 1'b0;
            r_cur      <= {1'b0, SYNC_PATTERN[7:1]};
            r_curLast  <= 1'b0;
            r_bitCnt   <= 4'd1;
            r_ones     <= SYNC_PATTERN[0] ? 3'd1 : 3'd0;
          end
        end

        ST_SYNC, ST_DATA: begin
          if (w_tick) begin
            if (w_boundary && !r_curLast && !r_holdValid) begin
              r_underrun <= 1'b1;
              r_state    <= ST_EOP_SE0;
              r_line     <= LINE_SE0;
              r_bitCnt   <= '0;
            end else if (w_stuff) begin
              r_line <= ~r_line;
              r_ones <= '0;
              if (w_boundary && !r_curLast) begin
                r_cur       <= r_hold;
                r_curLast   <= r_holdLast;
                r_holdValid <= 1'b0;
                r_bitCnt    <= '0;
                r_state     <= ST_DATA;
              end
            end else if (w_boundary && r_curLast) begin
              r_state  <= ST_EOP_SE0;
              r_line   <= LINE_SE0;
              r_bitCnt <= '0;
            end else begin
              // NRZI: a zero flips the line, a one holds it and extends the run
              if (w_sendBit) begin
                r_ones <= r_ones + 3'd1;
              end else begin
                r_line <= ~r_line;
                r_ones <= '0;
              end
              if (w_boundary) begin
                r_cur       <= {1'b0, r_hold[7:1]};
                r_curLast   <= r_holdLast;
                r_holdValid <= 1'b0;
                r_bitCnt    <= 4'd1;
                r_state     <= ST_DATA;
              end else begin
                r_cur    <= {1'b0, r_cur[7:1]};
                r_bitCnt <= r_bitCnt + 4'd1;
              end
            end
          end
        end

        ST_EOP_SE0: begin
          if (w_tick) begin
            if (r_bitCnt == 4'd1) begin
              r_state <= ST_EOP_J;
              r_line  <= lineJ(r_fs);
            end else begin
              r_bitCnt <= r_bitCnt + 4'd1;
            end
          end
        end

        ST_EOP_J: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_oe    <= 1'b0;
            r_trans <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

      // Capture and load are exclusive: capture needs an empty register, load a full one
      if (w_capture) begin
        r_hold      <= din;
        r_holdLast  <= last;
        r_holdValid <= 1'b1;
        r_wrout     <= wrin;
      end
    end
  end

  assign wrout            = r_wrout;
  assign {dm_out, dp_out} = r_line;
  assign oe               = r_oe;
  assign transmitting     = r_trans;
  assign underrun         = r_underrun;

endmodule

// File: doc/usb_tx.md
USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have parameter FS_BIT_CLKS, default 5, meaning clk60 cycles per full-speed bit (12 Mbit/s).
REQ-002 SHALL have parameter LS_BIT_CLKS, default 40, meaning clk60 cycles per low-speed bit (1.5 Mbit/s).
REQ-003 clk60  in  1  sole clock, 60 MHz, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 fullspeed  in  1  1 = full-speed line encoding and timing, 0 = low-speed.
REQ-006 din  in  8  payload byte from CPU, sent LSB first.
REQ-007 last  in  1  qualifies din; 1 = final byte of packet.
REQ-008 wrin  in  1  CPU write toggle; a request is pending while wrin != wrout.
REQ-009 wrout  out  1  acknowledge toggle; set to wrin when din/last are captured.
REQ-010 dp_out, dm_out  out  1 each  driven line levels.
REQ-011 oe  out  1  line driver enable.
REQ-012 transmitting  out  1  high from packet start until EOP J bit completes; feeds usbrx transmitting input.
REQ-013 underrun  out  1  sticky; set on data underrun, cleared at next packet start.

Function
REQ-014 Line states: J = {dm,dp} {0,1} full-speed, {1,0} low-speed; K = inverse of J; SE0 = {0,0}.
REQ-015 fullspeed SHALL be latched at packet start and held for the whole packet.
REQ-016 bit_tick SHALL pulse once every FS_BIT_CLKS or LS_BIT_CLKS cycles; counter cleared at packet start; each line state held exactly one bit period.
REQ-017 Holding register: one byte + last + valid; capture (wrout <= wrin, valid <= 1) on any cycle where request pending and valid = 0.
REQ-018 States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
REQ-019 IDLE: oe = 0, transmitting = 0, outputs J; holding-register valid -> SYNC next cycle, bit counter cleared, underrun cleared, transmitting = 1.
REQ-020 SYNC: send 8 bits of 8'h80 LSB first through NRZI, producing KJKJKJKK; first K visible the cycle after leaving IDLE.
REQ-021 NRZI: bit 0 toggles line J<->K; bit 1 holds level; encoder starts from J.
REQ-022 Bit stuffing: ones counter includes SYNC's final 1; after six consecutive 1s a 0 is inserted before the next bit; stuffed bit resets counter.
REQ-023 Shift register loads from holding register (valid <= 0) at each byte boundary; boundary at end of SYNC and after 8th unstuffed data bit.
REQ-024 Byte boundary with current byte last = 1 -> pending stuff bit (if ones = 6) sent, then EOP_SE0.
REQ-025 Byte boundary with last = 0 and valid = 0 -> underrun <= 1, go directly to EOP_SE0 (no stuff bit).
REQ-026 EOP_SE0: SE0 for 2 bit periods; EOP_J: J for 1 bit period; then IDLE, oe = 0, transmitting = 0 same cycle.
REQ-027 Capture during EOP or IDLE is allowed; that byte starts the next packet.
REQ-028 wrin toggle while valid = 1 SHALL remain pending, not lost.

Reset
REQ-029 reset SHALL force, next edge: state IDLE, oe 0, transmitting 0, {dm_out,dp_out} = J of current fullspeed, wrout 0, valid 0, underrun 0, counters 0.
REQ-030 reset mid-packet SHALL abort without EOP; wrin = 1 after reset is a new pending request.

Structure
REQ-031 Shared package usb_pkg SHALL hold state encoding, SYNC pattern 8'h80, stuff limit 6, bit-period constants, J/K/SE0 encodings.
REQ-032 Bit-tick generator SHALL be sub-module usb_bit_timer (inputs clk60, reset, clear, fullspeed; output tick).

Verification
REQ-033 FS, one byte 8'hC3 last = 1 -> KJKJKJKK, NRZI of C3, SE0 10 cycles, J 5 cycles, transmitting high 95 cycles.
REQ-034 LS, byte 8'hFF last = 1 -> stuff 0 after 5 data 1s (6 with SYNC 1), remaining bits, 80-cycle SE0, dm/dp polarity per low-speed.
REQ-035 FS, bytes 8'h3F then 8'h00 (last) toggled within 8 bit times -> continuous stream, stuff after 6th 1, no underrun.
REQ-036 FS, first byte last = 0 and no second write -> underrun = 1, SE0 directly after byte 1 bits, cleared at next start.
REQ-037 Reset asserted mid-DATA -> next cycle oe = 0, transmitting = 0, wrout = 0.
REQ-038 Loopback into usbrx with bytes 8'h2D, 8'h7E -> receiver returns identical bytes.
